ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit for the multi-cycle NPC core; the producing end of the `ifu_valid`/`idu_ready` handshake into the decoder. Holds the architectural PC, issues one word read per instruction on a valid/ready instruction-memory port, then presents `instr`/`pc` to the decoder. It waits for write-back (`wbu_valid`) to supply the next PC before fetching again, so exactly one instruction is in flight.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC loaded on reset.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ifu_valid`  out  1  `instr`/`pc` valid toward decoder.
- `idu_ready`  in  1  decoder accepts.
- `instr`  out  32  fetched instruction word.
- `pc`  out  32  address of `instr`.
- `fetch_fault`  out  1  fetch error qualifier, valid with `ifu_valid`.
- `wbu_valid`  in  1  current instruction retired; `dnpc` valid.
- `dnpc`  in  32  next PC from write-back.
- `imem_arvalid`  out  1  read request valid.
- `imem_arready`  in  1  memory accepts request.
- `imem_araddr`  out  32  read address (= `pc`).
- `imem_rvalid`  in  1  read data valid.
- `imem_rready`  out  1  IFU accepts read data.
- `imem_rdata`  in  32  read data.
- `imem_rresp`  in  2  response code; 2'b00 = OK.

## Operation
- States: FETCH, WAIT, DELIVER, EXEC. Reset state FETCH.
- FETCH: `imem_arvalid`=1, `imem_araddr`=`pc`. On `imem_arvalid && imem_arready` -> WAIT.
- WAIT: `imem_rready`=1. On `imem_rvalid`: register `imem_rdata` into `instr` -> DELIVER.
- DELIVER: `ifu_valid`=1; `instr`, `pc`, `fetch_fault` held stable. On `idu_ready` -> EXEC.
- EXEC: all handshake outputs 0. On `wbu_valid`: `pc` <= `dnpc` -> FETCH.
- Only one request outstanding; `imem_rvalid` outside WAIT is ignored (`imem_rready`=0).
- `wbu_valid` outside EXEC is ignored; `pc` unchanged.
- `dnpc` is used as-is; no alignment masking.
- `instr` changes only on WAIT->DELIVER; `pc` changes only on EXEC->FETCH and reset.

## Timing
- While `rst`=1 (sampled at edge): state <= FETCH, `pc` <= `RESET_PC`, `instr` <= 0, `fetch_fault` <= 0. Outputs `ifu_valid`, `imem_arvalid`, `imem_rready` forced 0 while `rst` is high.
- First `imem_arvalid`=1 in the first cycle after `rst` deasserts.
- Handshake outputs are decoded from registered state (Moore); no combinational path from `idu_ready`, `imem_*ready/valid` to outputs.
- Best case: request accepted cycle 0, `imem_rvalid` in cycle 1, `ifu_valid`=1 in cycle 2. Each stall cycle of `imem_arready`/`imem_rvalid` adds one cycle.
- `idu_ready` asserted in the first DELIVER cycle: one-cycle `ifu_valid` pulse.
- `wbu_valid` in EXEC: FETCH next cycle with new `pc` on `imem_araddr`.
- `imem_arvalid` never drops before acceptance; `imem_araddr` stable while pending.
- Reset mid-operation (any state): abandon transaction, return to FETCH with `RESET_PC`; memory is reset together with the core, so no stale response arrives.

## Configuration
- `IFU_FAULT_CHECK_EN` defined:
  - FETCH with `pc[1:0]`!=0: no memory request; next cycle DELIVER with `instr`=0, `fetch_fault`=1.
  - WAIT with `imem_rvalid` and `imem_rresp`!=0: DELIVER with `instr`=0, `fetch_fault`=1.
  - Otherwise `fetch_fault`=0.
- Undefined: `fetch_fault` tied 0; `imem_rresp` ignored; misaligned `pc` issued unchanged on `imem_araddr`.

## Test plan
- Reset release, memory always ready, rdata 32'h0000_0413 -> `imem_araddr`=32'h8000_0000 in cycle 0, `ifu_valid`=1 with `instr`=32'h0000_0413, `pc`=32'h8000_0000 in cycle 2.
- `imem_arready` low 3 cycles, `imem_rvalid` delayed 2 cycles -> `imem_arvalid`/`imem_araddr` held stable, `ifu_valid` at cycle 7; spurious `imem_rvalid` during FETCH ignored.
- `idu_ready` low 4 cycles in DELIVER -> `ifu_valid`, `instr`, `pc` stable 5 cycles; single EXEC entry.
- Retire with `dnpc`=32'h8000_0100; extra `wbu_valid` pulse in DELIVER -> only EXEC pulse taken, next `imem_araddr`=32'h8000_0100.
- `rst` asserted in WAIT and in DELIVER -> next cycle after release FETCH at 32'h8000_0000, `ifu_valid`=0 during reset.
- With `IFU_FAULT_CHECK_EN`: `dnpc`=32'h8000_0102 -> no `imem_arvalid`, `fetch_fault`=1, `instr`=0; `imem_rresp`=2'b10 -> `fetch_fault`=1. Without macro: same stimuli give `imem_araddr`=32'h8000_0102, `fetch_fault`=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one-instruction-in-flight fetch FSM feeding the decoder.
// Optional fault checking via IFU_FAULT_CHECK_EN (misaligned PC, bad read response).
//
// state   | meaning
// FETCH   | issue read at pc, wait for imem_arready
// WAIT    | accept read data on imem_rvalid
// DELIVER | present instr/pc to decoder until idu_ready
// EXEC    | instruction executing; wait for wbu_valid to load next pc
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_valid,
  input  logic        idu_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        fetch_fault,
  input  logic        wbu_valid,
  input  logic [31:0] dnpc,
  output logic        imem_arvalid,
  input  logic        imem_arready,
  output logic [31:0] imem_araddr,
  input  logic        imem_rvalid,
  output logic        imem_rready,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2,
    S_EXEC    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        w_load_instr;
  logic [31:0] w_instr_d;
  logic        w_load_pc;
  logic        w_misaligned;

`ifdef IFU_FAULT_CHECK_EN
  logic r_fault;
  logic w_fault_d;
  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign fetch_fault  = r_fault;
`else
  logic w_unused_rresp;
  assign w_unused_rresp = ^imem_rresp;
  assign w_misaligned   = 1'b0;
  assign fetch_fault    = 1'b0;
`endif

  always_comb begin
    w_next       = r_state;
    w_load_instr = 1'b0;
    w_instr_d    = imem_rdata;
    w_load_pc    = 1'b0;
`ifdef IFU_FAULT_CHECK_EN
    w_fault_d    = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        if (w_misaligned) begin
          // Faulting fetch skips memory entirely and delivers a null word.
          w_next       = S_DELIVER;
          w_load_instr = 1'b1;
          w_instr_d    = 32'h0;
`ifdef IFU_FAULT_CHECK_EN
          w_fault_d    = 1'b1;
`endif
        end else if (imem_arready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_next       = S_DELIVER;
          w_load_instr = 1'b1;
`ifdef IFU_FAULT_CHECK_EN
          if (imem_rresp != 2'b00) begin
            w_instr_d = 32'h0;
            w_fault_d = 1'b1;
          end
`endif
        end
      end
      S_DELIVER: begin
        if (idu_ready) w_next = S_EXEC;
      end
      S_EXEC: begin
        if (wbu_valid) begin
          w_next    = S_FETCH;
          w_load_pc = 1'b1;
        end
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
`ifdef IFU_FAULT_CHECK_EN
      r_fault <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_load_instr) begin
        r_instr <= w_instr_d;
`ifdef IFU_FAULT_CHECK_EN
        r_fault <= w_fault_d;
`endif
      end
      if (w_load_pc) r_pc <= dnpc;
    end
  end

  // Moore outputs; reset gating keeps the handshakes quiet during reset.
  assign imem_arvalid = (r_state == S_FETCH) && !w_misaligned && !rst;
  assign imem_rready  = (r_state == S_WAIT) && !rst;
  assign ifu_valid    = (r_state == S_DELIVER) && !rst;
  assign imem_araddr  = r_pc;
  assign pc           = r_pc;
  assign instr        = r_instr;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: vector table of fetch transactions plus reset corner sequences.
// Expected decoder outputs are queued per transaction and popped when ifu_valid rises.
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef IFU_FAULT_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_valid, idu_ready;
  logic [31:0] instr, pc;
  logic        fetch_fault;
  logic        wbu_valid;
  logic [31:0] dnpc;
  logic        imem_arvalid, imem_arready;
  logic [31:0] imem_araddr;
  logic        imem_rvalid, imem_rready;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .ifu_valid(ifu_valid), .idu_ready(idu_ready),
    .instr(instr), .pc(pc), .fetch_fault(fetch_fault),
    .wbu_valid(wbu_valid), .dnpc(dnpc),
    .imem_arvalid(imem_arvalid), .imem_arready(imem_arready), .imem_araddr(imem_araddr),
    .imem_rvalid(imem_rvalid), .imem_rready(imem_rready),
    .imem_rdata(imem_rdata), .imem_rresp(imem_rresp)
  );

  typedef struct {
    int          ar_stall;
    int          r_delay;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          idu_stall;
    bit          wbu_in_deliver;
    bit          spurious;
    int          exec_wait;
    logic [31:0] dnpc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  vec_t        vecs[5];
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    idu_ready    = 1'b0;
    wbu_valid    = 1'b0;
    dnpc         = 32'h0;
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    imem_rresp   = 2'b00;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   mis;
    int   cyc;
    mis     = FC && (model_pc[1:0] != 2'b00);
    e.pc    = model_pc;
    e.fault = mis || (FC && (v.rresp != 2'b00));
    e.instr = e.fault ? 32'h0 : v.rdata;
    sb.push_back(e);
    cyc = 0;
    if (mis) begin
      chk("arvalid_misaligned", {31'b0, imem_arvalid}, 32'd0);
      idle_inputs();
      @(negedge clk); cyc++;
    end else begin
      for (int k = 0; k <= v.ar_stall; k++) begin
        chk("arvalid", {31'b0, imem_arvalid}, 32'd1);
        chk("araddr", imem_araddr, model_pc);
        chk("rready_in_fetch", {31'b0, imem_rready}, 32'd0);
        imem_arready = (k == v.ar_stall);
        imem_rvalid  = v.spurious && (k < v.ar_stall);
        imem_rdata   = 32'hBAD0_0000 | k;
        @(negedge clk); cyc++;
      end
      idle_inputs();
      for (int k = 0; k <= v.r_delay; k++) begin
        chk("rready", {31'b0, imem_rready}, 32'd1);
        chk("arvalid_in_wait", {31'b0, imem_arvalid}, 32'd0);
        chk("ifu_valid_in_wait", {31'b0, ifu_valid}, 32'd0);
        imem_rvalid = (k == v.r_delay);
        imem_rdata  = v.rdata;
        imem_rresp  = v.rresp;
        @(negedge clk); cyc++;
      end
      idle_inputs();
    end
    chk("deliver_cycle", cyc, mis ? 32'd1 : (v.ar_stall + v.r_delay + 2));
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
    end
    for (int k = 0; k <= v.idu_stall; k++) begin
      chk("ifu_valid", {31'b0, ifu_valid}, 32'd1);
      chk("pc", pc, e.pc);
      chk("instr", instr, e.instr);
      chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
      chk("arvalid_in_deliver", {31'b0, imem_arvalid}, 32'd0);
      idu_ready = (k == v.idu_stall);
      wbu_valid = v.wbu_in_deliver && (k == 0);
      dnpc      = wbu_valid ? 32'hDEAD_0000 : 32'h0;
      @(negedge clk);
    end
    idle_inputs();
    for (int k = 0; k <= v.exec_wait; k++) begin
      chk("ifu_valid_in_exec", {31'b0, ifu_valid}, 32'd0);
      chk("arvalid_in_exec", {31'b0, imem_arvalid}, 32'd0);
      chk("rready_in_exec", {31'b0, imem_rready}, 32'd0);
      wbu_valid = (k == v.exec_wait);
      dnpc      = v.dnpc;
      @(negedge clk);
    end
    idle_inputs();
    model_pc = v.dnpc;
  endtask

  task automatic check_in_reset();
    chk("rst_ifu_valid", {31'b0, ifu_valid}, 32'd0);
    chk("rst_arvalid", {31'b0, imem_arvalid}, 32'd0);
    chk("rst_rready", {31'b0, imem_rready}, 32'd0);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    #1;
    sb.delete();
    model_pc = RESET_PC;
    chk("post_rst_arvalid", {31'b0, imem_arvalid}, 32'd1);
    chk("post_rst_araddr", imem_araddr, RESET_PC);
    chk("post_rst_ifu_valid", {31'b0, ifu_valid}, 32'd0);
  endtask

  // Drive into WAIT (and optionally DELIVER), then reset mid-transaction.
  task automatic reset_mid(input bit to_deliver);
    imem_arready = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("mid_rready", {31'b0, imem_rready}, 32'd1);
    if (to_deliver) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0BAD_F00D;
      @(negedge clk);
      idle_inputs();
      chk("mid_ifu_valid", {31'b0, ifu_valid}, 32'd1);
    end
    rst = 1'b1;
    #1;
    check_in_reset();
    @(negedge clk);
    check_in_reset();
    chk("mid_rst_pc", pc, RESET_PC);
    release_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ar r  rdata          rresp idu wbuD spur ex dnpc
    vecs[0] = '{0, 0, 32'h0000_0413, 2'b00, 0, 1'b0, 1'b0, 0, 32'h8000_0100};
    vecs[1] = '{3, 2, 32'h0010_0093, 2'b00, 4, 1'b1, 1'b1, 2, 32'h8000_0104};
    vecs[2] = '{1, 0, 32'hDEAD_BEEF, 2'b10, 0, 1'b0, 1'b0, 0, 32'h8000_0102};
    vecs[3] = '{0, 1, 32'h1234_5678, 2'b00, 1, 1'b0, 1'b0, 1, 32'h8000_0200};
    vecs[4] = '{2, 3, 32'h00A0_0513, 2'b00, 2, 1'b1, 1'b0, 0, 32'h8000_0000};

    rst = 1'b1;
    idle_inputs();
    model_pc = RESET_PC;
    repeat (3) @(negedge clk);
    check_in_reset();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    release_reset();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    reset_mid(1'b0);
    reset_mid(1'b1);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
